avmm_decode_mux: RTL and testbench
==================================

# avmm_decode_mux

Parametrised Avalon-MM one-to-N address-decoding router. It is the successor to the fixed four-port mux behind the LTPI target's AVMM controller tunnel. It adds:
- configurable port count and select field,
- a registered single-outstanding transaction FSM,
- write-response forwarding,
- decode-error and timeout responses,
- saturating error counters.

It sits between `mgmt_ltpi_top`'s `avalon_mm_m` and the local targets: FPGA interface, CSR block, and target models.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width, shared up/downstream.
- `DATA_WIDTH`, 32, data width; byteenable is `DATA_WIDTH/8`.
- `NUM_PORTS`, 4, downstream ports, 1–16.
- `SEL_LSB`, 8, lowest address bit of the port-select field.
- `SEL_W`, 4, select field width; requires `2**SEL_W >= NUM_PORTS`.
- `TIMEOUT_CYCLES`, 255, cycles from issue to forced error; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `s_address`/`s_read`/`s_write`/`s_writedata`/`s_byteenable`  in  ADDR_WIDTH/1/1/DATA_WIDTH/DATA_WIDTH/8  upstream command.
- `s_waitrequest`  out  1  upstream stall.
- `s_readdata`  out  DATA_WIDTH  read data.
- `s_readdatavalid`  out  1  read completion.
- `s_writeresponsevalid`  out  1  write completion.
- `s_response`  out  2  response code.
- `m_address`/`m_writedata`/`m_byteenable`  out  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  broadcast to all ports; select field forced to 0.
- `m_read`, `m_write`  out  NUM_PORTS  per-port strobes.
- `m_waitrequest`, `m_readdatavalid`, `m_writeresponsevalid`  in  NUM_PORTS  per-port.
- `m_readdata`  in  NUM_PORTS*DATA_WIDTH  port i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `m_response`  in  NUM_PORTS*2  port i at `[2i +: 2]`.
- `err_decode_cnt`, `err_timeout_cnt`  out  16  saturating counters.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Exactly one transaction is outstanding at a time.
- IDLE:
  - `s_waitrequest` = 0.
  - When `s_read` or `s_write` is high, the command is accepted that cycle. Address, data, byteenable, direction and `sel = s_address[SEL_LSB +: SEL_W]` are latched.
  - If both `s_read` and `s_write` are high, the read wins.
  - If `sel < NUM_PORTS`, go to ISSUE. Otherwise go to RESP with DECODEERROR (2'b11) and readdata 0, and increment `err_decode_cnt`.
- ISSUE:
  - Drive `m_read[sel]` or `m_write[sel]` with the latched command; all other strobe bits stay 0.
  - When `m_waitrequest[sel]` = 0, go to WAIT.
- WAIT: sample `m_readdatavalid[sel]` for reads or `m_writeresponsevalid[sel]` for writes. On a hit, latch `m_readdata`/`m_response` of `sel` and go to RESP.
- Timeout:
  - The counter clears on acceptance and counts every cycle spent in ISSUE or WAIT.
  - When it reaches `TIMEOUT_CYCLES` (nonzero), the strobes drop and the FSM goes to RESP with SLAVEERROR (2'b10) and readdata 32'hDEAD_BEEF; `err_timeout_cnt` increments.
  - Late completions from a timed-out port are ignored, because completions are sampled only in WAIT.
- RESP:
  - Pulse exactly one of `s_readdatavalid` or `s_writeresponsevalid` for one cycle, with `s_response` and `s_readdata` valid.
  - `s_readdata` = 0 for writes.
  - Return to IDLE.
- In every state other than IDLE, `s_waitrequest` = 1.
- Completions on non-selected ports are ignored.
- The error counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - FSM in IDLE; `busy` = 0 and `s_waitrequest` = 0.
  - All strobes and valids = 0.
  - `s_readdata` = 0 and `s_response` = 2'b00.
  - `m_*` data buses = 0 and both counters = 0.
- All outputs are registered, or decoded from the registered state only.
- Zero-wait read: accept at cycle 0, `m_read` at cycle 1, downstream `readdatavalid` at cycle 2 at earliest, `s_readdatavalid` at cycle 3. Next acceptance at cycle 4.
- Decode error: accept at cycle 0, response at cycle 1.
- Timeout with `TIMEOUT_CYCLES`=N: response at cycle N+1.
- If completion and timeout occur in the same cycle, the completion wins and the counter does not increment.
- Reset asserted mid-transaction aborts it immediately: strobes drop asynchronously and no response is produced.

## Structure
- `ltpi_pkg` additions:
  - `avmm_mux_state_t` enum.
  - `AVMM_RESP_OKAY` = 2'b00, `AVMM_RESP_SLVERR` = 2'b10, `AVMM_RESP_DECERR` = 2'b11.
  - `AVMM_TIMEOUT_RDATA` = 32'hDEAD_BEEF.
- Sub-module `avmm_sat_counter`: 16-bit saturating counter with increment input. It is instantiated once for the decode counter and once for the timeout counter.

## Test plan
- Read `0x0000_0104`; port 1 has zero wait and returns 32'h1234_5678 / OKAY → `m_read` = 4'b0010 and `m_address` = 0x0000_0004 at cycle 1; `s_readdatavalid` with 32'h1234_5678 at cycle 3.
- Write `0x0000_0308` with 32'hA5A5_A5A5; port 3 holds waitrequest for 3 cycles, then asserts writeresponsevalid → `s_writeresponsevalid` once with OKAY; port 3 sees the data; no other port strobes.
- Read `0x0000_0504` with NUM_PORTS=4 → DECODEERROR and readdata 0 at cycle 1; `err_decode_cnt` = 1; no `m_read` strobe.
- Port 2 never responds, `TIMEOUT_CYCLES`=8 → SLAVEERROR with 32'hDEAD_BEEF at cycle 9; `err_timeout_cnt` = 1; a late valid on port 2 is ignored and the next transaction completes normally.
- `rstn` deasserted during WAIT → all outputs return to reset values asynchronously; no spurious valid after `rstn` returns high.
- 65540 decode errors → `err_decode_cnt` holds at 16'hFFFF.

Source files
------------

// File: rtl/ltpi_pkg.sv
// Shared LTPI definitions: AVMM router state encoding, response codes and timeout fill data.
package ltpi_pkg;

  typedef enum logic [1:0] {
    MUX_IDLE  = 2'd0,
    MUX_ISSUE = 2'd1,
    MUX_WAIT  = 2'd2,
    MUX_RESP  = 2'd3
  } avmm_mux_state_t;

  localparam logic [1:0]  AVMM_RESP_OKAY     = 2'b00;
  localparam logic [1:0]  AVMM_RESP_SLVERR   = 2'b10;
  localparam logic [1:0]  AVMM_RESP_DECERR   = 2'b11;
  localparam logic [31:0] AVMM_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/avmm_sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, holds at all-ones.
// Registered output, no backpressure.
module avmm_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/avmm_decode_mux.sv
// Avalon-MM 1:N address-decode router, one outstanding transaction; zero-wait read = 3 cycles.
// Upstream stalled (s_waitrequest) whenever the FSM is not idle; downstream stall extends ISSUE.
module avmm_decode_mux
  import ltpi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_PORTS      = 4,
  parameter int SEL_LSB        = 8,
  parameter int SEL_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [ADDR_WIDTH-1:0]           s_address,
  input  logic                            s_read,
  input  logic                            s_write,
  input  logic [DATA_WIDTH-1:0]           s_writedata,
  input  logic [DATA_WIDTH/8-1:0]         s_byteenable,
  output logic                            s_waitrequest,
  output logic [DATA_WIDTH-1:0]           s_readdata,
  output logic                            s_readdatavalid,
  output logic                            s_writeresponsevalid,
  output logic [1:0]                      s_response,
  output logic [ADDR_WIDTH-1:0]           m_address,
  output logic [DATA_WIDTH-1:0]           m_writedata,
  output logic [DATA_WIDTH/8-1:0]         m_byteenable,
  output logic [NUM_PORTS-1:0]            m_read,
  output logic [NUM_PORTS-1:0]            m_write,
  input  logic [NUM_PORTS-1:0]            m_waitrequest,
  input  logic [NUM_PORTS-1:0]            m_readdatavalid,
  input  logic [NUM_PORTS-1:0]            m_writeresponsevalid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] m_readdata,
  input  logic [NUM_PORTS*2-1:0]          m_response,
  output logic [15:0]                     err_decode_cnt,
  output logic [15:0]                     err_timeout_cnt,
  output logic                            busy
);

  localparam int NSEL = 1 << SEL_W;
  localparam logic [ADDR_WIDTH-1:0] SEL_MASK =
    {{(ADDR_WIDTH-SEL_W){1'b0}}, {SEL_W{1'b1}}} << SEL_LSB;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  avmm_mux_state_t state_q, state_d;

  logic [SEL_W-1:0]      sel_in, sel_q;
  logic                  is_wr_q;
  logic [31:0]           tcnt_q;
  logic                  cmd, dec_ok, to_hit, done_hit, dec_inc, to_inc;
  logic [NSEL-1:0]       wait_pad, rvld_pad, wvld_pad;
  logic [DATA_WIDTH-1:0] rdata_arr [NSEL];
  logic [1:0]            resp_arr  [NSEL];
  logic [NUM_PORTS-1:0]  port_hit;

  // Pad per-port inputs out to the full select range so sel can index them directly.
  for (genvar i = 0; i < NSEL; i++) begin : g_pad
    if (i < NUM_PORTS) begin : g_real
      assign wait_pad[i]  = m_waitrequest[i];
      assign rvld_pad[i]  = m_readdatavalid[i];
      assign wvld_pad[i]  = m_writeresponsevalid[i];
      assign rdata_arr[i] = m_readdata[i*DATA_WIDTH +: DATA_WIDTH];
      assign resp_arr[i]  = m_response[2*i +: 2];
    end else begin : g_none
      assign wait_pad[i]  = 1'b1;
      assign rvld_pad[i]  = 1'b0;
      assign wvld_pad[i]  = 1'b0;
      assign rdata_arr[i] = '0;
      assign resp_arr[i]  = AVMM_RESP_OKAY;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_hit
    assign port_hit[i] = (sel_q == SEL_W'(i));
  end

  assign cmd      = s_read | s_write;
  assign sel_in   = s_address[SEL_LSB +: SEL_W];
  assign dec_ok   = 32'(sel_in) < 32'(NUM_PORTS);
  assign to_hit   = (TIMEOUT_CYCLES != 0) && (tcnt_q == TO_LAST);
  assign done_hit = (state_q == MUX_WAIT) && (is_wr_q ? wvld_pad[sel_q] : rvld_pad[sel_q]);
  assign dec_inc  = (state_q == MUX_IDLE) && cmd && !dec_ok;
  // A completion landing on the timeout cycle takes priority.
  assign to_inc   = ((state_q == MUX_ISSUE) || (state_q == MUX_WAIT)) && to_hit && !done_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= MUX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MUX_IDLE:  if (cmd) state_d = dec_ok ? MUX_ISSUE : MUX_RESP;
      MUX_ISSUE: begin
        if (to_hit)                  state_d = MUX_RESP;
        else if (!wait_pad[sel_q])   state_d = MUX_WAIT;
      end
      MUX_WAIT:  if (done_hit || to_hit) state_d = MUX_RESP;
      MUX_RESP:  state_d = MUX_IDLE;
      default:   state_d = MUX_IDLE;
    endcase
  end

  always_comb begin
    m_read               = '0;
    m_write              = '0;
    s_waitrequest        = (state_q != MUX_IDLE);
    busy                 = (state_q != MUX_IDLE);
    s_readdatavalid      = 1'b0;
    s_writeresponsevalid = 1'b0;
    if (state_q == MUX_ISSUE) begin
      if (is_wr_q) m_write = port_hit;
      else         m_read  = port_hit;
    end
    if (state_q == MUX_RESP) begin
      s_readdatavalid      = !is_wr_q;
      s_writeresponsevalid = is_wr_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_q        <= '0;
      is_wr_q      <= 1'b0;
      tcnt_q       <= '0;
      m_address    <= '0;
      m_writedata  <= '0;
      m_byteenable <= '0;
      s_readdata   <= '0;
      s_response   <= AVMM_RESP_OKAY;
    end else begin
      unique case (state_q)
        MUX_IDLE: begin
          if (cmd) begin
            sel_q        <= sel_in;
            is_wr_q      <= !s_read;
            tcnt_q       <= '0;
            m_address    <= s_address & ~SEL_MASK;
            m_writedata  <= s_writedata;
            m_byteenable <= s_byteenable;
            if (!dec_ok) begin
              s_readdata <= '0;
              s_response <= AVMM_RESP_DECERR;
            end
          end
        end
        MUX_ISSUE, MUX_WAIT: begin
          tcnt_q <= tcnt_q + 32'd1;
          if (done_hit) begin
            s_readdata <= is_wr_q ? '0 : rdata_arr[sel_q];
            s_response <= resp_arr[sel_q];
          end else if (to_hit) begin
            s_readdata <= is_wr_q ? '0 : DATA_WIDTH'(AVMM_TIMEOUT_RDATA);
            s_response <= AVMM_RESP_SLVERR;
          end
        end
        default: ;
      endcase
    end
  end

  avmm_sat_counter #(.WIDTH(16)) u_dec_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (dec_inc),
    .cnt  (err_decode_cnt)
  );

  avmm_sat_counter #(.WIDTH(16)) u_to_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (to_inc),
    .cnt  (err_timeout_cnt)
  );

endmodule

// File: tb/tb_avmm_decode_mux.sv
// Bench for avmm_decode_mux: directed scenarios plus randomized transactions against a latency/response model.
`timescale 1ns/1ps
module tb_avmm_decode_mux;

  localparam int NP = 4;
  localparam int TO = 8;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic        clk, rstn;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid, s_writeresponsevalid;
  logic [3:0]  s_byteenable, m_byteenable;
  logic [1:0]  s_response;
  logic [31:0] m_address, m_writedata;
  logic [NP-1:0] m_read, m_write, m_waitrequest, m_readdatavalid, m_writeresponsevalid;
  logic [NP*32-1:0] m_readdata;
  logic [NP*2-1:0]  m_response;
  logic [15:0] err_decode_cnt, err_timeout_cnt, sc_cnt;
  logic        busy, sc_inc;

  int checks = 0;
  int errors = 0;
  int exp_dec = 0;
  int exp_to = 0;

  avmm_decode_mux #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_PORTS(NP),
    .SEL_LSB(8), .SEL_W(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .s_writeresponsevalid(s_writeresponsevalid),
    .s_response(s_response),
    .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_read(m_read), .m_write(m_write),
    .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
    .m_writeresponsevalid(m_writeresponsevalid),
    .m_readdata(m_readdata), .m_response(m_response),
    .err_decode_cnt(err_decode_cnt), .err_timeout_cnt(err_timeout_cnt),
    .busy(busy)
  );

  avmm_sat_counter #(.WIDTH(16)) u_sat (
    .clk(clk), .rstn(rstn), .inc(sc_inc), .cnt(sc_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected outcome from the protocol rules: a port that releases waitrequest after w
  // stalled cycles and returns data d cycles into WAIT answers at cycle w+3+d, unless
  // that completion would land after the TO-th busy cycle.
  function automatic void ref_model(input int sel, input bit is_wr, input int w, input int d,
                                    input bit respond, input logic [31:0] prdata,
                                    input logic [1:0] presp, output int cyc,
                                    output logic [31:0] rdata, output logic [1:0] resp,
                                    output bit dec_err, output bit timed_out);
    cyc = 0; rdata = '0; resp = 2'b00; dec_err = 1'b0; timed_out = 1'b0;
    if (sel >= NP) begin
      cyc = 1; resp = 2'b11; dec_err = 1'b1;
    end else if (respond && (w + 2 + d <= TO)) begin
      cyc = w + 3 + d; resp = presp; rdata = is_wr ? 32'h0 : prdata;
    end else begin
      cyc = TO + 1; resp = 2'b10; rdata = is_wr ? 32'h0 : DEAD; timed_out = 1'b1;
    end
  endfunction

  // Issues one command at the current negedge (cycle 0) and plays every downstream port
  // cycle by cycle; non-selected ports emit random noise.
  task automatic run_txn(input logic [31:0] addr, input bit rd, input bit wr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int w, input int d, input bit respond,
                         input logic [31:0] prdata, input logic [1:0] presp,
                         output int o_cyc, output logic [31:0] o_rdata, output logic [1:0] o_resp,
                         output int o_rv, output int o_wv, output int o_bad, output int o_scyc,
                         output logic [31:0] o_maddr, output logic [31:0] o_mwdata,
                         output logic [3:0] o_mbe, output bit o_idle);
    int  sel, scnt, acc;
    bit  is_wr, st, vnow;
    sel = int'(addr[11:8]);
    is_wr = !rd;
    scnt = 0; acc = -1;
    o_cyc = -1; o_rdata = '0; o_resp = '0; o_rv = 0; o_wv = 0; o_bad = 0; o_scyc = -1;
    o_maddr = '0; o_mwdata = '0; o_mbe = '0; o_idle = 1'b0;
    s_address = addr; s_read = rd; s_write = wr; s_writedata = wdata; s_byteenable = be;
    m_readdatavalid = '0; m_writeresponsevalid = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        s_read = 1'b0; s_write = 1'b0; s_address = $urandom; s_writedata = $urandom;
      end
      if (o_cyc < 0 && !s_waitrequest) o_bad++;
      if (s_readdatavalid) o_rv++;
      if (s_writeresponsevalid) o_wv++;
      if ((s_readdatavalid || s_writeresponsevalid) && o_cyc < 0) begin
        o_cyc = c; o_rdata = s_readdata; o_resp = s_response;
      end
      for (int p = 0; p < NP; p++) begin
        if (m_read[p] && (is_wr || p != sel)) o_bad++;
        if (m_write[p] && (!is_wr || p != sel)) o_bad++;
      end
      st = (sel < NP) && (is_wr ? m_write[sel[1:0]] : m_read[sel[1:0]]);
      if (st && o_scyc < 0) begin
        o_scyc = c; o_maddr = m_address; o_mwdata = m_writedata; o_mbe = m_byteenable;
      end
      if (st && acc >= 0) o_bad++;
      m_waitrequest = 4'($urandom);
      m_readdatavalid = 4'($urandom);
      m_writeresponsevalid = 4'($urandom);
      m_readdata = {$urandom, $urandom, $urandom, $urandom};
      m_response = 8'($urandom);
      if (sel < NP) begin
        if (st) begin
          scnt++;
          if (scnt > w && acc < 0) acc = c;
        end
        m_waitrequest[sel[1:0]] = !(st && scnt > w);
        vnow = respond && (acc >= 0) && (c == acc + 1 + d);
        m_readdatavalid[sel[1:0]] = vnow && !is_wr;
        m_writeresponsevalid[sel[1:0]] = vnow && is_wr;
        m_readdata[sel*32 +: 32] = prdata;
        m_response[sel*2 +: 2] = presp;
      end
      if (o_cyc > 0 && c == o_cyc + 1) begin
        o_idle = !s_waitrequest && !busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (s_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitreq: got %b want 0", s_waitrequest); end
    checks++; if ({m_read, m_write} !== 8'h00) begin errors++; $display("FAIL reset_strobes: got %h want 00", {m_read, m_write}); end
    checks++; if ({s_readdatavalid, s_writeresponsevalid} !== 2'b00) begin errors++; $display("FAIL reset_valids: got %b want 00", {s_readdatavalid, s_writeresponsevalid}); end
    checks++; if (s_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", s_readdata); end
    checks++; if (s_response !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b want 00", s_response); end
    checks++; if ({m_address, m_writedata, m_byteenable} !== 68'h0) begin errors++; $display("FAIL reset_mbus: got %h %h %h want 0", m_address, m_writedata, m_byteenable); end
    checks++; if ({err_decode_cnt, err_timeout_cnt} !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h %h want 0", err_decode_cnt, err_timeout_cnt); end
  endtask

  task automatic test_read_basic();
    int cyc, rv, wv, bad, scyc; logic [31:0] rd, ma, mw; logic [1:0] rs; logic [3:0] mb; bit idle;
    run_txn(32'h0000_0104, 1'b1, 1'b0, $urandom, 4'hF, 0, 0, 1'b1, 32'h1234_5678, 2'b00,
            cyc, rd, rs, rv, wv, bad, scyc, ma, mw, mb, idle);
    checks++; if (scyc !== 1) begin errors++; $display("FAIL rd_strobe_cycle: got %0d want 1", scyc); end
    checks++; if (ma !== 32'h4) begin errors++; $display("FAIL rd_maddr: got %h want 00000004", ma); end
    checks++; if (cyc !== 3) begin errors++; $display("FAIL rd_resp_cycle: got %0d want 3", cyc); end
    checks++; if (rd !== 32'h1234_5678 || rs !== 2'b00) begin errors++; $display("FAIL rd_data: got %h/%b want 12345678/00", rd, rs); end
    checks++; if (rv !== 1 || wv !== 0 || bad !== 0 || !idle) begin errors++; $display("FAIL rd_protocol: rv %0d wv %0d bad %0d idle %0d want 1 0 0 1", rv, wv, bad, idle); end
  endtask

  task automatic test_write_wait();
    int cyc, rv, wv, bad, scyc; logic [31:0] rd, ma, mw; logic [1:0] rs; logic [3:0] mb; bit idle;
    run_txn(32'h0000_0308, 1'b0, 1'b1, 32'hA5A5_A5A5, 4'b0110, 3, 0, 1'b1, 32'h0, 2'b00,
            cyc, rd, rs, rv, wv, bad, scyc, ma, mw, mb, idle);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL wr_resp_cycle: got %0d want 6", cyc); end
    checks++; if (wv !== 1 || rv !== 0) begin errors++; $display("FAIL wr_valid: got wv %0d rv %0d want 1 0", wv, rv); end
    checks++; if (rs !== 2'b00 || rd !== 32'h0) begin errors++; $display("FAIL wr_resp: got %b/%h want 00/0", rs, rd); end
    checks++; if (mw !== 32'hA5A5_A5A5 || mb !== 4'b0110 || ma !== 32'h8) begin errors++; $display("FAIL wr_mbus: got %h %b %h want a5a5a5a5 0110 8", mw, mb, ma); end
    checks++; if (bad !== 0 || !idle) begin errors++; $display("FAIL wr_protocol: bad %0d idle %0d want 0 1", bad, idle); end
  endtask

  task automatic test_decode_err();
    int cyc, rv, wv, bad, scyc; logic [31:0] rd, ma, mw; logic [1:0] rs; logic [3:0] mb; bit idle;
    run_txn(32'h0000_0504, 1'b1, 1'b0, $urandom, 4'hF, 0, 0, 1'b1, 32'hFFFF_FFFF, 2'b00,
            cyc, rd, rs, rv, wv, bad, scyc, ma, mw, mb, idle);
    exp_dec++;
    checks++; if (cyc !== 1) begin errors++; $display("FAIL dec_cycle: got %0d want 1", cyc); end
    checks++; if (rs !== 2'b11 || rd !== 32'h0 || rv !== 1) begin errors++; $display("FAIL dec_resp: got %b/%h rv %0d want 11/0 1", rs, rd, rv); end
    checks++; if (scyc !== -1 || bad !== 0) begin errors++; $display("FAIL dec_no_strobe: scyc %0d bad %0d want -1 0", scyc, bad); end
    checks++; if (err_decode_cnt !== 16'(exp_dec)) begin errors++; $display("FAIL dec_cnt: got %0d want %0d", err_decode_cnt, exp_dec); end
  endtask

  task automatic test_timeout();
    int cyc, rv, wv, bad, scyc, ecyc; logic [31:0] rd, ma, mw, erd, pd; logic [1:0] rs, ers;
    logic [3:0] mb; bit idle, edec, eto, spur;
    run_txn(32'h0000_0210, 1'b1, 1'b0, $urandom, 4'hF, 0, 0, 1'b0, 32'h0, 2'b00,
            cyc, rd, rs, rv, wv, bad, scyc, ma, mw, mb, idle);
    exp_to++;
    checks++; if (cyc !== TO + 1) begin errors++; $display("FAIL to_cycle: got %0d want %0d", cyc, TO + 1); end
    checks++; if (rs !== 2'b10 || rd !== DEAD) begin errors++; $display("FAIL to_resp: got %b/%h want 10/deadbeef", rs, rd); end
    checks++; if (err_timeout_cnt !== 16'(exp_to)) begin errors++; $display("FAIL to_cnt: got %0d want %0d", err_timeout_cnt, exp_to); end
    spur = 1'b0;
    m_readdatavalid = 4'b0100; m_writeresponsevalid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (s_readdatavalid || s_writeresponsevalid || busy) spur = 1'b1;
    end
    m_readdatavalid = '0;
    checks++; if (spur) begin errors++; $display("FAIL to_late_valid: got spurious response want none"); end
    pd = $urandom;
    ref_model(2, 1'b0, 1, 2, 1'b1, pd, 2'b00, ecyc, erd, ers, edec, eto);
    run_txn(32'h0000_0220, 1'b1, 1'b0, $urandom, 4'hF, 1, 2, 1'b1, pd, 2'b00,
            cyc, rd, rs, rv, wv, bad, scyc, ma, mw, mb, idle);
    checks++; if (cyc !== ecyc || rd !== erd || rs !== ers || rv !== 1 || bad !== 0) begin errors++; $display("FAIL to_recover: got c%0d %h %b rv%0d bad%0d want c%0d %h %b rv1 bad0", cyc, rd, rs, rv, bad, ecyc, erd, ers); end
  endtask

  task automatic test_timeout_tie();
    int cyc, rv, wv, bad, scyc; logic [31:0] rd, ma, mw; logic [1:0] rs; logic [3:0] mb; bit idle;
    run_txn(32'h0000_0100, 1'b1, 1'b0, $urandom, 4'hF, 0, TO - 2, 1'b1, 32'hCAFE_0001, 2'b00,
            cyc, rd, rs, rv, wv, bad, scyc, ma, mw, mb, idle);
    checks++; if (cyc !== TO + 1 || rs !== 2'b00 || rd !== 32'hCAFE_0001) begin errors++; $display("FAIL tie_completion: got c%0d %b %h want c%0d 00 cafe0001", cyc, rs, rd, TO + 1); end
    checks++; if (err_timeout_cnt !== 16'(exp_to)) begin errors++; $display("FAIL tie_cnt: got %0d want %0d", err_timeout_cnt, exp_to); end
    run_txn(32'h0000_0000, 1'b0, 1'b1, $urandom, 4'hF, 2, TO - 3, 1'b1, 32'h0, 2'b00,
            cyc, rd, rs, rv, wv, bad, scyc, ma, mw, mb, idle);
    exp_to++;
    checks++; if (cyc !== TO + 1 || rs !== 2'b10 || rd !== 32'h0 || wv !== 1) begin errors++; $display("FAIL late_by_one: got c%0d %b %h wv%0d want c%0d 10 0 1", cyc, rs, rd, wv, TO + 1); end
    run_txn(32'h0000_0300, 1'b0, 1'b1, $urandom, 4'hF, 20, 0, 1'b1, 32'h0, 2'b00,
            cyc, rd, rs, rv, wv, bad, scyc, ma, mw, mb, idle);
    exp_to++;
    checks++; if (cyc !== TO + 1 || rs !== 2'b10 || bad !== 0) begin errors++; $display("FAIL issue_stall_to: got c%0d %b bad%0d want c%0d 10 0", cyc, rs, bad, TO + 1); end
    checks++; if (err_timeout_cnt !== 16'(exp_to)) begin errors++; $display("FAIL stall_cnt: got %0d want %0d", err_timeout_cnt, exp_to); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int sel, mode, w, d, ecyc, cyc, rv, wv, bad, scyc;
      logic [31:0] addr, wd, pd, erd, rd, ma, mw; logic [3:0] be, mb; logic [1:0] ps, ers, rs;
      bit rdb, wrb, rsp, edec, eto, idle;
      sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 2));
      rdb = (mode != 1); wrb = (mode != 0);
      addr = $urandom; addr[11:8] = 4'(sel);
      wd = $urandom; pd = $urandom; be = 4'($urandom); ps = 2'($urandom);
      w = int'($urandom_range(0, 4)); d = int'($urandom_range(0, 8));
      rsp = ($urandom_range(0, 4) != 0);
      ref_model(sel, !rdb, w, d, rsp, pd, ps, ecyc, erd, ers, edec, eto);
      if (edec) exp_dec++;
      if (eto) exp_to++;
      run_txn(addr, rdb, wrb, wd, be, w, d, rsp, pd, ps, cyc, rd, rs, rv, wv, bad, scyc, ma, mw, mb, idle);
      checks++; if (cyc !== ecyc || rd !== erd || rs !== ers) begin errors++; $display("FAIL rnd_resp[%0d]: got c%0d %h %b want c%0d %h %b", i, cyc, rd, rs, ecyc, erd, ers); end
      checks++; if (rv !== (rdb ? 1 : 0) || wv !== (rdb ? 0 : 1) || bad !== 0 || !idle) begin errors++; $display("FAIL rnd_proto[%0d]: rv%0d wv%0d bad%0d idle%0d", i, rv, wv, bad, idle); end
      if (sel < NP) begin
        checks++; if (scyc !== 1 || ma !== (addr & 32'hFFFF_F0FF) || mw !== wd || mb !== be) begin errors++; $display("FAIL rnd_mbus[%0d]: got s%0d %h %h %h want s1 %h %h %h", i, scyc, ma, mw, mb, addr & 32'hFFFF_F0FF, wd, be); end
      end
      checks++; if (err_decode_cnt !== 16'(exp_dec) || err_timeout_cnt !== 16'(exp_to)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d %0d want %0d %0d", i, err_decode_cnt, err_timeout_cnt, exp_dec, exp_to); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, rv, wv, bad, scyc; logic [31:0] rd, ma, mw; logic [1:0] rs; logic [3:0] mb; bit idle, spur;
    s_address = 32'h0000_00F4; s_read = 1'b1; s_write = 1'b0;
    m_waitrequest = '0; m_readdatavalid = '0; m_writeresponsevalid = '0;
    @(negedge clk); s_read = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || s_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b %b want 1 1", busy, s_waitrequest); end
    #2 rstn = 1'b0;
    #1;
    exp_dec = 0; exp_to = 0;
    checks++; if (busy !== 1'b0 || s_waitrequest !== 1'b0 || m_read !== 4'h0) begin errors++; $display("FAIL mid_async: busy %b wr %b m_read %b want 0 0 0", busy, s_waitrequest, m_read); end
    checks++; if (m_address !== 32'h0 || s_readdata !== 32'h0 || s_response !== 2'b00 || s_readdatavalid !== 1'b0) begin errors++; $display("FAIL mid_values: %h %h %b %b want 0", m_address, s_readdata, s_response, s_readdatavalid); end
    @(negedge clk); rstn = 1'b1;
    m_readdatavalid = 4'hF; m_writeresponsevalid = 4'hF;
    spur = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_readdatavalid || s_writeresponsevalid || busy) spur = 1'b1;
    end
    m_readdatavalid = '0; m_writeresponsevalid = '0;
    checks++; if (spur) begin errors++; $display("FAIL mid_spurious: got response after reset want none"); end
    run_txn(32'h0000_0040, 1'b1, 1'b0, $urandom, 4'hF, 0, 1, 1'b1, 32'h0BAD_F00D, 2'b00,
            cyc, rd, rs, rv, wv, bad, scyc, ma, mw, mb, idle);
    checks++; if (cyc !== 4 || rd !== 32'h0BAD_F00D || rv !== 1) begin errors++; $display("FAIL mid_recover: got c%0d %h rv%0d want c4 0badf00d 1", cyc, rd, rv); end
  endtask

  task automatic test_saturation();
    int model;
    model = 0;
    sc_inc = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      @(negedge clk);
      model++;
    end
    checks++; if (sc_cnt !== 16'(model)) begin errors++; $display("FAIL sat_near: got %h want %h", sc_cnt, 16'(model)); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      model++;
    end
    sc_inc = 1'b0;
    if (model > 65535) model = 65535;
    checks++; if (sc_cnt !== 16'(model)) begin errors++; $display("FAIL sat_hold: got %h want %h", sc_cnt, 16'(model)); end
  endtask

  initial begin
    rstn = 1'b0; sc_inc = 1'b0;
    s_address = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0; s_byteenable = '0;
    m_waitrequest = '1; m_readdatavalid = '0; m_writeresponsevalid = '0;
    m_readdata = '0; m_response = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    @(negedge clk);
    test_read_basic();
    test_write_wait();
    test_decode_err();
    test_timeout();
    test_timeout_tie();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
